// File: rtl/polar_pkg.sv
// Shared constants and helpers for the polar decoder partial-sum memories.
// Holds the default widths, a constant-safe log2 and the per-layer beat count.
package polar_pkg;

  localparam int Q_DEF = 6;
  localparam int P_DEF = 64;
  localparam int N_DEF = 1024;

  typedef logic [4:0] layer_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Beats needed to move a layer of 2^l entries through a P-entry bus.
  function automatic int beats(input int l, input int p);
    int lp;
    lp = clog2(p);
    return (l <= lp) ? 1 : (1 << (l - lp));
  endfunction

endpackage

// File: rtl/beta_layer_mem_if.sv
// Write/read bus of the layered partial-sum memory.
// The memory side uses the slave modport, the producer/consumer the master.
interface beta_layer_mem_if #(
  parameter int P  = 64,
  parameter int Q  = 6,
  parameter int CW = 2
);

  logic                  clr;
  logic                  w_en;
  polar_pkg::layer_t     w_layer;
  logic [CW-1:0]         w_cnt;
  logic [P*Q-1:0]        w_data;
  logic                  r_en;
  polar_pkg::layer_t     r_layer;
  logic [CW-1:0]         r_cnt;
  logic [P*Q-1:0]        r_data;
  logic                  r_valid;
  logic                  r_hit;
  logic                  err;

  modport master (
    output clr, w_en, w_layer, w_cnt, w_data, r_en, r_layer, r_cnt,
    input  r_data, r_valid, r_hit, err
  );

  modport slave (
    input  clr, w_en, w_layer, w_cnt, w_data, r_en, r_layer, r_cnt,
    output r_data, r_valid, r_hit, err
  );

endinterface

// File: rtl/beta_layer_bank.sv
// Storage for one layer: ROWS beats of LANES entries, one write port and one
// registered read port that returns same-cycle write data on an address match.
module beta_layer_bank
  import polar_pkg::*;
#(
  parameter int ENTRIES = 2,
  parameter int P       = P_DEF,
  parameter int Q       = Q_DEF,
  localparam int ROWS   = (ENTRIES > P) ? ENTRIES / P : 1,
  localparam int LANES  = (ENTRIES > P) ? P : ENTRIES,
  localparam int AW     = (ROWS > 1) ? clog2(ROWS) : 1,
  localparam int WW     = LANES * Q
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [WW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [WW-1:0] rdata_o
);

  logic [WW-1:0] mem_q [ROWS];
  logic [WW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) mem_q[r] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/beta_layer_mem.sv
// Layered partial-sum memory: one bank per layer 1..L_MAX, with layer decode,
// access legality, per-layer written flags and zero-padded read muxing.
module beta_layer_mem
  import polar_pkg::*;
#(
  parameter int Q     = Q_DEF,
  parameter int P     = P_DEF,
  parameter int N     = N_DEF,
  parameter int L_MAX = clog2(N) - 2
) (
  input logic             clk,
  input logic             rst,
  beta_layer_mem_if.slave bus
);

  localparam int DW = P * Q;

  int               wl;
  int               rl;
  logic             wLegal;
  logic             rLegal;
  logic [L_MAX:1]   wSel;
  logic [L_MAX:1]   rSel;
  logic [L_MAX:1]   flags_q;
  logic [L_MAX:1]   flags_d;
  logic [L_MAX:1]   rsel_q;
  logic             rhit_d;
  logic             rhit_q;
  logic             err_d;
  logic             err_q;
  logic [DW-1:0]    bankData [1:L_MAX];
  logic [DW-1:0]    rData;

  // r_hit reads the flag after this edge's clr/write so it agrees with forwarding.
  always_comb begin
    wl      = int'(bus.w_layer);
    rl      = int'(bus.r_layer);
    wLegal  = bus.w_en && (wl >= 1) && (wl <= L_MAX) && (int'(bus.w_cnt) < beats(wl, P));
    rLegal  = bus.r_en && (rl >= 1) && (rl <= L_MAX) && (int'(bus.r_cnt) < beats(rl, P));
    flags_d = bus.clr ? '0 : flags_q;
    wSel    = '0;
    rSel    = '0;
    rhit_d  = 1'b0;
    for (int l = 1; l <= L_MAX; l++) begin
      wSel[l] = wLegal && (wl == l);
      rSel[l] = rLegal && (rl == l);
      if (wSel[l]) flags_d[l] = 1'b1;
    end
    for (int l = 1; l <= L_MAX; l++) begin
      if (rSel[l]) rhit_d = flags_d[l];
    end
    err_d = (bus.w_en && !wLegal) || (bus.r_en && !rLegal);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      rsel_q  <= '0;
      rhit_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      rsel_q  <= rSel;
      rhit_q  <= rhit_d;
      err_q   <= err_d;
    end
  end

  for (genvar g = 1; g <= L_MAX; g++) begin : gLayer
    localparam int ENTRIES = 1 << g;
    localparam int ROWS    = beats(g, P);
    localparam int AW      = (ROWS > 1) ? clog2(ROWS) : 1;
    localparam int WW      = ((ENTRIES < P) ? ENTRIES : P) * Q;

    logic [WW-1:0] bankRd;

    beta_layer_bank #(
      .ENTRIES (ENTRIES),
      .P       (P),
      .Q       (Q)
    ) uBank (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wSel[g]),
      .waddr_i (bus.w_cnt[AW-1:0]),
      .wdata_i (bus.w_data[WW-1:0]),
      .re_i    (rSel[g]),
      .raddr_i (bus.r_cnt[AW-1:0]),
      .rdata_o (bankRd)
    );

    assign bankData[g] = DW'(bankRd);
  end

  // rsel_q is one-hot or zero, so an idle or illegal read yields all-zero data.
  always_comb begin
    rData = '0;
    for (int l = 1; l <= L_MAX; l++) begin
      if (rsel_q[l]) rData = bankData[l];
    end
  end

  assign bus.r_data  = rData;
  assign bus.r_valid = |rsel_q;
  assign bus.r_hit   = rhit_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_beta_layer_mem.sv
// Self-checking bench for beta_layer_mem: directed scenarios then random traffic,
// each cycle checked against an entry-level reference model of the layer memory.
module tb_beta_layer_mem;

  localparam int P     = 64;
  localparam int Q     = 6;
  localparam int N     = 1024;
  localparam int L_MAX = 8;
  localparam int CW    = 2;
  localparam int DW    = P * Q;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  beta_layer_mem_if #(.P(P), .Q(Q), .CW(CW)) bus ();

  beta_layer_mem #(.Q(Q), .P(P), .N(N), .L_MAX(L_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: raw entries per layer plus one written flag per layer.
  logic [Q-1:0] refMem [1:L_MAX][0:255];
  bit           refFlag [1:L_MAX];

  function automatic int beatsOf(input int l);
    if (l < 1 || l > L_MAX) return 0;
    return ((1 << l) < P) ? 1 : (1 << l) / P;
  endfunction

  function automatic bit legal(input int l, input int c);
    return c < beatsOf(l);
  endfunction

  function automatic logic [DW-1:0] pat(input int c);
    logic [DW-1:0] d;
    for (int i = 0; i < P; i++) d[i*Q +: Q] = Q'((c * P + i) % 64);
    return d;
  endfunction

  function automatic logic [DW-1:0] fill(input logic [Q-1:0] v);
    logic [DW-1:0] d;
    for (int i = 0; i < P; i++) d[i*Q +: Q] = v;
    return d;
  endfunction

  function automatic logic [DW-1:0] randData();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] eData, input logic eValid,
                             input logic eHit, input logic eErr);
    total++;
    assert (bus.r_data === eData) else begin
      bad++;
      $error("FAIL %s r_data got=%h want=%h", tag, bus.r_data, eData);
    end
    total++;
    assert (bus.r_valid === eValid) else begin
      bad++;
      $error("FAIL %s r_valid got=%b want=%b", tag, bus.r_valid, eValid);
    end
    total++;
    assert (bus.r_hit === eHit) else begin
      bad++;
      $error("FAIL %s r_hit got=%b want=%b", tag, bus.r_hit, eHit);
    end
    total++;
    assert (bus.err === eErr) else begin
      bad++;
      $error("FAIL %s err got=%b want=%b", tag, bus.err, eErr);
    end
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then checks.
  task automatic applyStimulus(input string tag, input bit wen, input int wl, input int wc,
                               input logic [DW-1:0] wd, input bit ren, input int rl,
                               input int rc, input bit clrIn);
    logic [DW-1:0] eData;
    logic eValid, eHit, eErr;
    bit wOk, rOk;
    bus.w_en    = wen;
    bus.w_layer = wl[4:0];
    bus.w_cnt   = wc[CW-1:0];
    bus.w_data  = wd;
    bus.r_en    = ren;
    bus.r_layer = rl[4:0];
    bus.r_cnt   = rc[CW-1:0];
    bus.clr     = clrIn;
    wOk    = wen && legal(wl, wc);
    rOk    = ren && legal(rl, rc);
    eData  = '0;
    eValid = 1'b0;
    eHit   = 1'b0;
    eErr   = 1'b0;
    if (rst) begin
      for (int l = 1; l <= L_MAX; l++) begin
        refFlag[l] = 1'b0;
        for (int e = 0; e < 256; e++) refMem[l][e] = '0;
      end
    end else begin
      if (clrIn) for (int l = 1; l <= L_MAX; l++) refFlag[l] = 1'b0;
      if (wOk) begin
        refFlag[wl] = 1'b1;
        for (int i = 0; i < P && i < (1 << wl); i++) refMem[wl][wc*P + i] = wd[i*Q +: Q];
      end
      if (rOk) begin
        eValid = 1'b1;
        eHit   = refFlag[rl];
        for (int i = 0; i < P && i < (1 << rl); i++) eData[i*Q +: Q] = refMem[rl][rc*P + i];
      end
      eErr = (wen && !wOk) || (ren && !rOk);
    end
    @(posedge clk);
    #1;
    checkOutput(tag, eData, eValid, eHit, eErr);
  endtask

  initial begin
    logic [DW-1:0] dA, dB;
    int wl, rl;
    $display("[TB] beta_layer_mem bench start");
    rst = 1'b1;
    applyStimulus("reset0", 0, 0, 0, '0, 0, 0, 0, 0);
    applyStimulus("reset1", 0, 0, 0, '0, 1, 8, 0, 0);
    rst = 1'b0;
    applyStimulus("idle", 0, 0, 0, '0, 0, 0, 0, 0);

    for (int c = 0; c < 4; c++) applyStimulus("l8_write", 1, 8, c, pat(c), 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) applyStimulus("l8_read", 0, 0, 0, '0, 1, 8, c, 0);
    applyStimulus("l8_idle", 0, 0, 0, '0, 0, 0, 0, 0);

    applyStimulus("l3_write", 1, 3, 0, fill(6'h3F), 0, 0, 0, 0);
    applyStimulus("l3_read", 0, 0, 0, '0, 1, 3, 0, 0);

    dA = randData();
    dB = randData();
    applyStimulus("l7_wr0", 1, 7, 0, dA, 0, 0, 0, 0);
    applyStimulus("l7_wr1", 1, 7, 1, dB, 0, 0, 0, 0);
    applyStimulus("l7_fwd", 1, 7, 1, fill(6'h15), 1, 7, 1, 0);
    applyStimulus("l7_old", 0, 0, 0, '0, 1, 7, 0, 0);
    applyStimulus("l7_rd1", 0, 0, 0, '0, 1, 7, 1, 0);

    applyStimulus("l2_write", 1, 2, 0, randData(), 0, 0, 0, 0);
    applyStimulus("bad_wl0", 1, 0, 0, randData(), 0, 0, 0, 0);
    applyStimulus("err_drop", 0, 0, 0, '0, 0, 0, 0, 0);
    applyStimulus("bad_rl9", 0, 0, 0, '0, 1, 9, 0, 0);
    applyStimulus("bad_rcnt", 0, 0, 0, '0, 1, 2, 1, 0);
    applyStimulus("bad_wcnt", 1, 2, 1, randData(), 1, 2, 0, 0);
    applyStimulus("l2_intact", 0, 0, 0, '0, 1, 2, 0, 0);
    applyStimulus("l8_intact", 0, 0, 0, '0, 1, 8, 3, 0);

    applyStimulus("l5_write", 1, 5, 0, randData(), 0, 0, 0, 0);
    applyStimulus("clr", 0, 0, 0, '0, 0, 0, 0, 1);
    applyStimulus("l5_nohit", 0, 0, 0, '0, 1, 5, 0, 0);
    applyStimulus("clr_wr", 1, 5, 0, randData(), 0, 0, 0, 1);
    applyStimulus("l5_hit", 0, 0, 0, '0, 1, 5, 0, 0);
    applyStimulus("clr_wr_rd", 1, 6, 0, randData(), 1, 6, 0, 1);
    applyStimulus("l5_after", 0, 0, 0, '0, 1, 5, 0, 0);

    rst = 1'b1;
    applyStimulus("rst_read", 1, 4, 0, randData(), 1, 8, 0, 0);
    rst = 1'b0;
    applyStimulus("post_rst8", 0, 0, 0, '0, 1, 8, 0, 0);
    applyStimulus("post_rst7", 0, 0, 0, '0, 1, 7, 1, 0);
    applyStimulus("post_rst3", 0, 0, 0, '0, 1, 3, 0, 0);

    for (int n = 0; n < 400; n++) begin
      wl = $urandom_range(0, 10);
      rl = ($urandom % 2 == 0) ? wl : $urandom_range(0, 10);
      applyStimulus("random", bit'($urandom % 2), wl, $urandom_range(0, 3), randData(),
                    bit'($urandom % 2), rl, $urandom_range(0, 3), bit'($urandom % 16 == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
